// File: rtl/wavefront_controller.sv
// Wavefront controller: sequences an N x M PE array one anti-diagonal at a time.
// Optional watchdog (WAVEFRONT_WATCHDOG_EN) adds a stall counter and an ERROR state.
module wavefront_controller #(
   parameter  int N  = 4,
   parameter  int M  = 4,
   localparam int D  = N + M - 1,
   localparam int DW = (D > 1) ? $clog2(D) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            go,
   input  logic [N*M-1:0]  pe_done,
   output logic [N*M-1:0]  pe_start,
   output logic            pe_clear,
   output logic            busy,
   output logic [DW-1:0]   diag,
   output logic            finished,
   output logic            error,
   output logic [2:0]      state_dbg
);

   // Handshake: go is a one-cycle request honoured only in IDLE (or ERROR); pe_done
   // bits are levels, and a diagonal completes in the first WAIT cycle where every
   // member cell reports done at once.

`ifdef WAVEFRONT_WATCHDOG_EN
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_WAIT, S_DONE, S_ERROR} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_WAIT, S_DONE} state_t;
`endif

   localparam int            NMASK     = 1 << DW;
   localparam logic [DW-1:0] LAST_DIAG = DW'(D - 1);

   function automatic logic [N*M-1:0] diag_mask_f(input int d);
      logic [N*M-1:0] m;
      m = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < M; j++)
            if (i + j == d) m[i*M + j] = 1'b1;
      return m;
   endfunction

   // Membership table is fixed at elaboration; entries past D-1 are empty.
   logic [N*M-1:0] mask_tbl [NMASK];
   generate
      for (genvar g = 0; g < NMASK; g++) begin : g_mask
         localparam logic [N*M-1:0] MASK = diag_mask_f(g);
         assign mask_tbl[g] = MASK;
      end
   endgenerate

   state_t         state, state_n;
   logic [DW-1:0]  diag_q, diag_n;
   logic [N*M-1:0] cur_mask;
   logic           diag_complete;

   assign cur_mask      = mask_tbl[diag_q];
   assign diag_complete = &(pe_done | ~cur_mask);

`ifdef WAVEFRONT_WATCHDOG_EN
   logic [3:0] wd_cnt, wd_n;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         diag_q <= '0;
`ifdef WAVEFRONT_WATCHDOG_EN
         wd_cnt <= '0;
`endif
      end else begin
         state  <= state_n;
         diag_q <= diag_n;
`ifdef WAVEFRONT_WATCHDOG_EN
         wd_cnt <= wd_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      diag_n  = diag_q;
`ifdef WAVEFRONT_WATCHDOG_EN
      wd_n    = wd_cnt;
`endif
      case (state)
         S_IDLE:  if (go) state_n = S_CLEAR;
         S_CLEAR: begin
            diag_n  = '0;
            state_n = S_ISSUE;
         end
         S_ISSUE: begin
            state_n = S_WAIT;
`ifdef WAVEFRONT_WATCHDOG_EN
            wd_n    = '0;
`endif
         end
         S_WAIT: begin
            if (diag_complete) begin
               if (diag_q == LAST_DIAG) begin
                  state_n = S_DONE;
               end else begin
                  diag_n  = diag_q + DW'(1);
                  state_n = S_ISSUE;
               end
            end
`ifdef WAVEFRONT_WATCHDOG_EN
            // Sixteenth consecutive stalled WAIT cycle trips the watchdog.
            else if (wd_cnt == 4'hF) begin
               state_n = S_ERROR;
            end else begin
               wd_n = wd_cnt + 4'd1;
            end
`endif
         end
         S_DONE:  state_n = S_IDLE;
`ifdef WAVEFRONT_WATCHDOG_EN
         S_ERROR: if (go) state_n = S_CLEAR;
`endif
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      pe_start = '0;
      pe_clear = 1'b0;
      finished = 1'b0;
      error    = 1'b0;
      busy     = (state != S_IDLE);
      case (state)
         S_CLEAR: pe_clear = 1'b1;
         S_ISSUE: pe_start = cur_mask;
         S_DONE:  finished = 1'b1;
`ifdef WAVEFRONT_WATCHDOG_EN
         S_ERROR: error    = 1'b1;
`endif
         default: ;
      endcase
   end

   assign diag      = diag_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_wavefront_controller.sv
// Bench for wavefront_controller on a 3x2 array: directed passes plus randomized PE
// latencies, checked against a schedule derived from the anti-diagonal rules.
module tb_wavefront_controller;

   localparam int TN  = 3;
   localparam int TM  = 2;
   localparam int TD  = TN + TM - 1;
   localparam int TDW = 2;
   localparam int K   = TN * TM;

   logic           clk = 1'b0;
   logic           reset;
   logic           go;
   logic [K-1:0]   pe_done;
   logic [K-1:0]   pe_start;
   logic           pe_clear;
   logic           busy;
   logic [TDW-1:0] diag;
   logic           finished;
   logic           error;
   logic [2:0]     state_dbg;

   int checks   = 0;
   int failures = 0;
   int dly[K];
   int seen;

   always #5 clk = ~clk;

   wavefront_controller #(.N(TN), .M(TM)) dut (
      .clk       (clk),
      .reset     (reset),
      .go        (go),
      .pe_done   (pe_done),
      .pe_start  (pe_start),
      .pe_clear  (pe_clear),
      .busy      (busy),
      .diag      (diag),
      .finished  (finished),
      .error     (error),
      .state_dbg (state_dbg)
   );

   function automatic int cell_diag(input int k);
      return (k / TM) + (k % TM);
   endfunction

   function automatic logic [K-1:0] exp_mask(input int d);
      logic [K-1:0] m;
      m = '0;
      for (int k = 0; k < K; k++)
         if (cell_diag(k) == d) m[k] = 1'b1;
      return m;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_pe_start"}, 32'(pe_start), 32'(0));
      check({tag, "_pe_clear"}, 32'(pe_clear), 32'(0));
      check({tag, "_busy"}, 32'(busy), 32'(0));
      check({tag, "_diag"}, 32'(diag), 32'(0));
      check({tag, "_finished"}, 32'(finished), 32'(0));
      check({tag, "_error"}, 32'(error), 32'(0));
      check({tag, "_state_known"}, 32'($isunknown(state_dbg)), 32'(0));
   endtask

   // Called from an IDLE cycle; go is raised in that cycle (cycle 0).
   task automatic run_pass(input bit go_noise, input int reset_at, output int seen_finish);
      int t_issue[TD];
      int t, mx, fin, cd;
      logic [K-1:0] dn, es;
      t = 2;
      fin = 0;
      for (int d = 0; d < TD; d++) begin
         mx = 0;
         for (int k = 0; k < K; k++)
            if (cell_diag(k) == d && dly[k] > mx) mx = dly[k];
         t_issue[d] = t;
         t = t + mx + 1;
      end
      fin = t;
      seen_finish = -1;
      go = 1'b1;
      for (int c = 1; c <= fin + 1; c++) begin
         step();
         go    = go_noise && (c == 3 || c == 5);
         reset = (c == reset_at);
         cd = -1;
         if (c >= 2)
            for (int d = 0; d < TD; d++)
               if (t_issue[d] <= c) cd = d;
         dn = '0;
         for (int k = 0; k < K; k++) begin
            if (cell_diag(k) < cd) dn[k] = 1'($urandom_range(0, 1));
            else if (cell_diag(k) == cd && c >= t_issue[cd] + dly[k]) dn[k] = 1'b1;
         end
         pe_done = dn;
         es = '0;
         for (int d = 0; d < TD; d++)
            if (c == t_issue[d]) es = exp_mask(d);
         check("pe_start", 32'(pe_start), 32'(es));
         check("pe_clear", 32'(pe_clear), 32'(c == 1));
         check("busy", 32'(busy), 32'(c <= fin));
         check("finished", 32'(finished), 32'(c == fin));
         check("error", 32'(error), 32'(0));
         if (c >= 2) check("diag", 32'(diag), 32'(cd));
         if (finished === 1'b1 && seen_finish < 0) seen_finish = c;
         if (c == reset_at) begin
            step();
            reset   = 1'b0;
            go      = 1'b0;
            pe_done = '0;
            check_reset_vals("abort");
            for (int i = 0; i < 5; i++) begin
               step();
               check("finished_after_abort", 32'(finished), 32'(0));
               check("busy_after_abort", 32'(busy), 32'(0));
            end
            return;
         end
      end
      go = 1'b0;
   endtask

   // Cell 0 never completes; called from an IDLE cycle.
   task automatic run_stall();
      go      = 1'b1;
      pe_done = '0;
      for (int c = 1; c <= 40; c++) begin
         step();
         go = 1'b0;
         check("stall_pe_clear", 32'(pe_clear), 32'(c == 1));
         check("stall_pe_start", 32'(pe_start), (c == 2) ? 32'(exp_mask(0)) : 32'(0));
         check("stall_busy", 32'(busy), 32'(1));
`ifdef WAVEFRONT_WATCHDOG_EN
         check("stall_error", 32'(error), 32'(c >= 19));
`else
         check("stall_error", 32'(error), 32'(0));
         if (c >= 2) check("stall_diag", 32'(diag), 32'(0));
`endif
      end
`ifdef WAVEFRONT_WATCHDOG_EN
      go = 1'b1;
      step();
      go = 1'b0;
      check("wd_restart_clear", 32'(pe_clear), 32'(1));
      check("wd_restart_error", 32'(error), 32'(0));
`endif
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_reset_vals("stall_abort");
   endtask

   initial begin
      reset   = 1'b1;
      go      = 1'b1;
      pe_done = '0;
      for (int i = 0; i < 3; i++) step();
      check_reset_vals("reset_with_go");
      reset = 1'b0;
      go    = 1'b0;
      step();
      check_reset_vals("idle");

      for (int k = 0; k < K; k++) dly[k] = 1;
      run_pass(1'b0, 0, seen);
      check("budget_unit", 32'(seen), 32'(2 * TD + 2));
      check("idle_diag_hold", 32'(diag), 32'(TD - 1));

      dly[2] = 5;
      run_pass(1'b0, 0, seen);
      check("budget_slow_cell", 32'(seen), 32'(2 * TD + 2 + 4));

      for (int k = 0; k < K; k++) dly[k] = 1;
      run_pass(1'b1, 0, seen);
      check("budget_go_noise", 32'(seen), 32'(2 * TD + 2));

      run_pass(1'b0, 4, seen);
      check("abort_no_finish", 32'(seen), 32'(-1));

      run_pass(1'b0, 0, seen);
      check("budget_after_abort", 32'(seen), 32'(2 * TD + 2));

      for (int p = 0; p < 8; p++) begin
         for (int k = 0; k < K; k++) dly[k] = $urandom_range(1, 4);
         run_pass(1'($urandom_range(0, 1)), 0, seen);
         check("random_finish_seen", 32'(seen > 0), 32'(1));
      end

      run_stall();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
